// File: rtl/sample_ctrl_pkg.sv
// Shared constants for the sample-capture APB window: register offsets,
// register bit positions and the capture sequencer state encoding.
package sample_ctrl_pkg;

  localparam logic [11:0] CTRL_OFS   = 12'hBA0;
  localparam logic [11:0] PERIOD_OFS = 12'hBA4;
  localparam logic [11:0] STATUS_OFS = 12'hBA8;
  localparam logic [11:0] SAMPLE_OFS = 12'hBAC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_COR_BIT   = 1;
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sample_period_timer.sv
// Periodic capture timer: down-counter reloaded with PERIOD-1, one-cycle tick
// every PERIOD cycles while enabled with a non-zero period.
module sample_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                reload,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_p1;
  logic                armed_p1;
  logic                active;

  assign active = en && (period != '0);
  // armed_p1 is clear on the first active cycle so the count always starts at PERIOD-1
  assign tick   = active && armed_p1 && !reload && (cnt_p1 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1   <= '0;
      armed_p1 <= 1'b0;
    end else if (!active) begin
      cnt_p1   <= '0;
      armed_p1 <= 1'b0;
    end else if (reload || !armed_p1 || (cnt_p1 == '0)) begin
      cnt_p1   <= period - PERIOD_W'(1);
      armed_p1 <= 1'b1;
    end else begin
      cnt_p1   <= cnt_p1 - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/sample_apb_ctrl.sv
// APB4 slave for the sample-capture window: register file, capture-on-read
// sequencing and merging of timer and read capture requests into one strobe.
module sample_apb_ctrl
  import sample_ctrl_pkg::*;
#(
  parameter int PERIOD_W     = 16,
  parameter int RESET_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        cap_strobe,
  input  logic [31:0] sample_rdata
);

  cap_state_e          state_p1, state_nx;
  logic [1:0]          ctrl_p1;
  logic [PERIOD_W-1:0] period_p1;
  logic                valid_p1, ovr_p1, tmr_req_p1, reload_p1;
  logic                setup, access, idle_acc, addr_ok, acc_err, wr_ok;
  logic                wr_ctrl, wr_period, wr_status, rd_sample_done;
  logic                go_capt, tick, timer_cap;
  logic [31:0]         rd_mux;
  logic                unused_pwdata;

  assign unused_pwdata = ^pwdata;

  // Stage 0: APB decode
  assign setup    = psel && !penable;
  assign access   = psel && penable;
  assign addr_ok  = paddr inside {CTRL_OFS, PERIOD_OFS, STATUS_OFS, SAMPLE_OFS};
  assign acc_err  = !addr_ok || (pwrite && (paddr == SAMPLE_OFS));
  assign idle_acc = access && (state_p1 == IDLE);
  assign wr_ok    = idle_acc && pwrite && !acc_err;

  assign wr_ctrl   = wr_ok && (paddr == CTRL_OFS);
  assign wr_period = wr_ok && (paddr == PERIOD_OFS);
  assign wr_status = wr_ok && (paddr == STATUS_OFS);

  assign go_capt = (state_p1 == IDLE) && setup && !pwrite &&
                   (paddr == SAMPLE_OFS) && ctrl_p1[CTRL_COR_BIT];

  assign rd_sample_done = (idle_acc && !pwrite && (paddr == SAMPLE_OFS)) ||
                          (state_p1 == RESP);

  // A tick landing in CAPT rides on the strobe already being issued
  assign timer_cap = (cap_strobe && tmr_req_p1) || (tick && (state_p1 == CAPT));

  sample_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (ctrl_p1[CTRL_EN_BIT]),
    .reload (reload_p1),
    .period (period_p1),
    .tick   (tick)
  );

  always_comb begin
    rd_mux = '0;
    case (paddr)
      CTRL_OFS: begin
        rd_mux[CTRL_EN_BIT]  = ctrl_p1[CTRL_EN_BIT];
        rd_mux[CTRL_COR_BIT] = ctrl_p1[CTRL_COR_BIT];
      end
      PERIOD_OFS: rd_mux = 32'(period_p1);
      STATUS_OFS: begin
        rd_mux[STAT_VALID_BIT] = valid_p1;
        rd_mux[STAT_OVR_BIT]   = ovr_p1;
      end
      SAMPLE_OFS: rd_mux = sample_rdata;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nx = state_p1;
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    case (state_p1)
      IDLE: begin
        if (go_capt) state_nx = CAPT;
        if (access) begin
          pready  = 1'b1;
          pslverr = acc_err;
          if (!pwrite && !acc_err) prdata = rd_mux;
        end
      end
      CAPT: state_nx = RESP;
      RESP: begin
        state_nx = IDLE;
        pready   = 1'b1;
        prdata   = sample_rdata;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1: registered state, strobe and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1   <= IDLE;
      cap_strobe <= 1'b0;
      tmr_req_p1 <= 1'b0;
      reload_p1  <= 1'b0;
      ctrl_p1    <= '0;
      period_p1  <= PERIOD_W'(RESET_PERIOD);
      valid_p1   <= 1'b0;
      ovr_p1     <= 1'b0;
    end else begin
      state_p1   <= state_nx;
      cap_strobe <= go_capt || (tick && (state_p1 != CAPT));
      tmr_req_p1 <= tick && (state_p1 != CAPT);
      reload_p1  <= wr_period;
      if (wr_ctrl) begin
        ctrl_p1[CTRL_EN_BIT]  <= pwdata[CTRL_EN_BIT];
        ctrl_p1[CTRL_COR_BIT] <= pwdata[CTRL_COR_BIT];
      end
      if (wr_period) period_p1 <= pwdata[PERIOD_W-1:0];
      if (timer_cap)           valid_p1 <= 1'b1;
      else if (rd_sample_done) valid_p1 <= 1'b0;
      if (timer_cap && valid_p1)                  ovr_p1 <= 1'b1;
      else if (wr_status && pwdata[STAT_OVR_BIT]) ovr_p1 <= 1'b0;
    end
  end

endmodule
